// File: rtl/oracle_query_sequencer.sv
// oracle_query_sequencer
//
// Takes one query pattern per valid/ready handshake and drives it on the
// inputs of a combinational oracle. It waits SETTLE cycles, then captures
// the oracle outputs. If the query asked for it, the capture is compared
// against an expected value. The result goes out over a second
// valid/ready handshake. Completed responses and mismatching responses are
// counted in saturating counters.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   abort      : synchronous abort of any query in flight
//   q_valid    : query valid
//   q_ready    : query ready (IDLE, no abort, not in reset)
//   q_data     : input pattern for the oracle
//   q_exp      : expected oracle response
//   q_chk      : compare the response against q_exp for this query
//   dut_in     : registered drive to the oracle inputs
//   dut_out    : oracle outputs, combinational function of dut_in
//   r_valid    : response valid
//   r_ready    : response ready
//   r_data     : captured oracle response
//   r_mismatch : q_chk was set and the captured response differed from q_exp
//   busy       : a query is in flight (state != IDLE)
//   query_cnt  : completed responses, saturating
//   err_cnt    : mismatching responses, saturating
module oracle_query_sequencer #(
  parameter int IN_W   = 36,
  parameter int OUT_W  = 7,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [IN_W-1:0]  q_data,
  input  logic [OUT_W-1:0] q_exp,
  input  logic             q_chk,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [OUT_W-1:0] r_data,
  output logic             r_mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] query_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // The settle counter only has to reach SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [SW-1:0]    settle_cnt;
  logic [OUT_W-1:0] exp_reg;
  logic             chk_reg;

  logic accept;
  logic capture;
  logic complete;

  // The state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the per-edge events. Abort overrides any handshake
  // that is in progress, so none of the events fire while abort is high.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    q_ready    = rst_n && !abort && (state == IDLE);

    case (state)
      IDLE: begin
        if (q_valid && q_ready) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == LAST) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (r_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next = IDLE;
      accept     = 1'b0;
      capture    = 1'b0;
      complete   = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  // Datapath: the oracle drive, the settle timer, the response capture
  // and the statistics counters. An abort clears only the drive and the
  // response valid. The counters and the captured data keep their values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_in     <= '0;
      exp_reg    <= '0;
      chk_reg    <= 1'b0;
      settle_cnt <= '0;
      r_data     <= '0;
      r_mismatch <= 1'b0;
      r_valid    <= 1'b0;
      query_cnt  <= '0;
      err_cnt    <= '0;
    end else if (abort) begin
      dut_in  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (accept) begin
        dut_in     <= q_data;
        exp_reg    <= q_exp;
        chk_reg    <= q_chk;
        settle_cnt <= '0;
      end

      if (state == DRIVE && !capture) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      if (capture) begin
        r_data     <= dut_out;
        r_mismatch <= chk_reg && (dut_out != exp_reg);
        r_valid    <= 1'b1;
      end

      if (complete) begin
        r_valid <= 1'b0;
        if (query_cnt != CNT_MAX) begin
          query_cnt <= query_cnt + CNT_W'(1);
        end
        if (r_mismatch && err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/oracle_query_sequencer.md
Name: oracle_query_sequencer

Overview:
Sequences query vectors into a combinational oracle (for example the 36-in/7-out c432 interrupt-priority netlist, locked or unlocked) for the SAT-attack and defense evaluation flow. It accepts one input pattern per valid/ready handshake, drives the pattern on the oracle inputs, and waits a programmable settle time. It then captures the oracle outputs, optionally compares them against an expected value, and returns the result over a second valid/ready handshake. Query and mismatch statistics are kept in saturating counters.

Parameters:
IN_W, 36, oracle input width (width of q_data and dut_in)
OUT_W, 7, oracle output width (width of dut_out, q_exp and r_data)
SETTLE, 2, cycles from query accept to output capture; must be >= 1
CNT_W, 16, width of query_cnt and err_cnt

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
abort  in  1  synchronous abort of any query in flight
q_valid  in  1  query valid
q_ready  out  1  query ready; high only in IDLE with abort=0 and rst_n=1
q_data  in  IN_W  input pattern for the oracle
q_exp  in  OUT_W  expected oracle response
q_chk  in  1  enables comparison against q_exp for this query
dut_in  out  IN_W  registered drive to the oracle inputs
dut_out  in  OUT_W  oracle outputs, combinational function of dut_in
r_valid  out  1  response valid
r_ready  in  1  response ready
r_data  out  OUT_W  captured oracle response
r_mismatch  out  1  set when q_chk=1 and captured response != q_exp
busy  out  1  state != IDLE
query_cnt  out  CNT_W  completed responses, saturating
err_cnt  out  CNT_W  mismatching responses, saturating

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - dut_in, r_data, r_mismatch, r_valid, query_cnt and err_cnt all go to 0.
  - The settle counter clears.
  - q_ready is 0 while rst_n=0.
  - Reset asserted mid-query discards that query; no response is produced.
- FSM states:
  - IDLE to DRIVE when q_valid & q_ready. On that edge: dut_in<=q_data, exp/chk registers<=q_exp/q_chk, settle counter<=0.
  - DRIVE: the counter increments each edge. On the edge where counter==SETTLE-1:
    - r_data<=dut_out
    - r_mismatch<=chk_reg & (dut_out!=exp_reg)
    - r_valid<=1
    - state goes to RESP.
  - RESP: r_valid, r_data and r_mismatch hold stable until r_valid & r_ready. On that edge:
    - r_valid<=0
    - query_cnt++
    - err_cnt++ if r_mismatch
    - state goes to IDLE.
- Timing:
  - r_valid rises exactly SETTLE edges after the accept edge.
  - q_ready returns high the cycle after the response handshake.
  - Minimum query period is SETTLE+2 cycles.
  - A query and a response are never accepted in the same cycle.
- dut_in holds its value from the accept edge until the next accept, abort or reset. It does not change during DRIVE or RESP.
- abort: on any edge with abort=1, outside reset:
  - State goes to IDLE.
  - r_valid<=0 and dut_in<=0.
  - Counters are unchanged.
  - abort wins over a simultaneous q or r handshake. That handshake does not complete and no counter updates.
- Counters saturate at 2^CNT_W-1 and never wrap.
- r_mismatch and r_data keep their last value after the handshake. They are meaningful only while r_valid=1.
- q_valid, q_data, q_exp and q_chk are ignored outside IDLE.

Test Plan:
- Oracle stub in the bench: dut_out = dut_in[6:0] ^ 7'h55.
- Reset: hold rst_n=0 for 2 edges, then release -> r_valid=0, dut_in=0, query_cnt=0, err_cnt=0, busy=0. q_ready=0 during reset and 1 after release.
- Basic query, SETTLE=2: q_data=36'h00000002A, q_chk=0, accepted at edge T0 -> dut_in=36'h2A after T0; r_valid=1 and r_data=7'h7F after T2; r_ready=1 completes at T3 -> query_cnt=1; q_ready=1 after T3; a second query is accepted at T4.
- Backpressure: hold r_ready=0 for 5 cycles in RESP while q_valid=1 -> r_valid=1, r_data stable, q_ready=0, no accept, dut_in unchanged; raising r_ready completes the handshake.
- Compare:
  - q_data=36'h2A, q_exp=7'h00, q_chk=1 -> r_mismatch=1, err_cnt=1.
  - q_exp=7'h7F, q_chk=1 -> r_mismatch=0, err_cnt stays 1.
  - q_chk=0 with a wrong q_exp -> r_mismatch=0.
- Abort/reset mid-operation:
  - abort at the edge after accept (DRIVE) -> IDLE, r_valid never rises, dut_in=0, query_cnt unchanged.
  - abort coincident with r_valid & r_ready -> query_cnt unchanged.
  - rst_n=0 in RESP -> all outputs return to reset values.
- Saturation, CNT_W=4: 17 mismatching queries -> query_cnt=15, err_cnt=15, no wrap.
